// File: rtl/feeder_pkg.sv
// Shared types and constants for the frame line feeder: sequencer states,
// packing of pixels into frame-memory words and default raster dimensions.
package feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SCAN,
    ST_FLUSH,
    ST_FIN
  } state_e;

  localparam int PIX_PER_WORD = 4;
  localparam int DEF_IMG_W    = 512;
  localparam int DEF_IMG_H    = 480;

  function automatic int words_per_line(input int imgW);
    return imgW / PIX_PER_WORD;
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Wrap-around counter used for the word, pixel and row positions of the raster.
// last_o flags the terminal value so the caller can detect the wrap edge.
module raster_counter #(
  parameter int WIDTH = 9,
  parameter int MAX   = 512
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign last_o  = (count_q == WIDTH'(MAX - 1));
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/frame_line_feeder.sv
// Write-side raster sequencer: loads frame rows into the line buffer and, between
// loads, scans the centre row so each pixel neighbourhood is offered downstream.
module frame_line_feeder
  import feeder_pkg::*;
#(
  parameter int IMG_W  = DEF_IMG_W,
  parameter int IMG_H  = DEF_IMG_H,
  parameter int MEM_AW = 17
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic [31:0]       lb_datain,
  output logic [8:0]        lb_address,
  output logic [8:0]        lb_vertical_count,
  output logic              lb_save_data,
  output logic              win_valid,
  input  logic              win_ready
);

  localparam int WPL = words_per_line(IMG_W);

  state_e state_q, state_d;
  logic   tail_q, tail_d;
  logic   lastScan_q, lastScan_d;
  logic   pend_q;
  logic [8:0] pendWord_q;

  logic       cntClr, wordEn, pixEn, rowEn;
  logic [8:0] word, pix, row;
  logic       wordLast, pixLast, rowLast;

  raster_counter #(.WIDTH(9), .MAX(WPL)) uWord (
    .clk(clk), .reset(reset), .clear_i(cntClr), .en_i(wordEn),
    .count_o(word), .last_o(wordLast)
  );

  raster_counter #(.WIDTH(9), .MAX(IMG_W)) uPix (
    .clk(clk), .reset(reset), .clear_i(cntClr), .en_i(pixEn),
    .count_o(pix), .last_o(pixLast)
  );

  raster_counter #(.WIDTH(9), .MAX(IMG_H)) uRow (
    .clk(clk), .reset(reset), .clear_i(cntClr), .en_i(rowEn),
    .count_o(row), .last_o(rowLast)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tail_q     <= 1'b0;
      lastScan_q <= 1'b0;
      pend_q     <= 1'b0;
      pendWord_q <= '0;
    end else begin
      state_q    <= state_d;
      tail_q     <= tail_d;
      lastScan_q <= lastScan_d;
      pend_q     <= mem_rd_en;
      pendWord_q <= word;
    end
  end

  // A pending read lands one cycle after issue and is written straight through.
  always_comb begin
    state_d           = state_q;
    tail_d            = tail_q;
    lastScan_d        = lastScan_q;
    cntClr            = 1'b0;
    wordEn            = 1'b0;
    pixEn             = 1'b0;
    rowEn             = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    mem_rd_en         = 1'b0;
    mem_addr          = '0;
    lb_datain         = '0;
    lb_address        = '0;
    lb_vertical_count = '0;
    lb_save_data      = 1'b0;
    win_valid         = 1'b0;

    if (pend_q) begin
      lb_save_data = 1'b1;
      lb_datain    = mem_rdata;
      lb_address   = pendWord_q << 2;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_LOAD;
          cntClr     = 1'b1;
          tail_d     = 1'b0;
          lastScan_d = 1'b0;
        end
      end
      ST_LOAD: begin
        busy              = 1'b1;
        lb_vertical_count = row;
        if (!tail_q) begin
          mem_rd_en = 1'b1;
          mem_addr  = MEM_AW'(row) * MEM_AW'(WPL) + MEM_AW'(word);
          wordEn    = 1'b1;
          if (wordLast) tail_d = 1'b1;
        end else begin
          tail_d = 1'b0;
          if (row == '0) begin
            rowEn = 1'b1;
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        // The centre row trails the newest loaded row by one, except after the flush.
        busy              = 1'b1;
        win_valid         = 1'b1;
        lb_address        = pix;
        lb_vertical_count = lastScan_q ? row : row - 9'd1;
        if (win_ready) begin
          pixEn = 1'b1;
          if (pixLast) begin
            if (lastScan_q) begin
              state_d = ST_FIN;
            end else if (rowLast) begin
              state_d = ST_FLUSH;
            end else begin
              rowEn   = 1'b1;
              state_d = ST_LOAD;
            end
          end
        end
      end
      ST_FLUSH: begin
        busy              = 1'b1;
        lb_save_data      = 1'b1;
        lb_vertical_count = row;
        lastScan_d        = 1'b1;
        state_d           = ST_SCAN;
      end
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_frame_line_feeder.sv
// Directed bench for frame_line_feeder on an 8x3 raster with a one-cycle-latency
// frame memory whose word at address a is 32'hA500_0000 | a.
module tb_frame_line_feeder;

  localparam int W   = 8;
  localparam int H   = 3;
  localparam int WPL = W / 4;
  localparam int AW  = 17;

  logic          clk = 1'b0;
  logic          reset, start, win_ready;
  logic          busy, done, mem_rd_en, lb_save_data, win_valid;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_rdata, lb_datain;
  logic [8:0]    lb_address, lb_vertical_count;

  int checks = 0;
  int errors = 0;
  int saves, wins, dones, overlaps;

  frame_line_feeder #(.IMG_W(W), .IMG_H(H), .MEM_AW(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .lb_datain(lb_datain), .lb_address(lb_address),
    .lb_vertical_count(lb_vertical_count), .lb_save_data(lb_save_data),
    .win_valid(win_valid), .win_ready(win_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memWord(input int a);
    return 32'hA500_0000 | 32'(a);
  endfunction

  // Frame memory model: data valid one cycle after the read strobe, junk otherwise.
  always @(posedge clk) begin
    mem_rdata <= mem_rd_en ? memWord(int'(mem_addr)) : 32'hDEAD_BEEF;
  end

  always @(posedge clk) begin
    if (!reset) begin
      if (lb_save_data)            saves++;
      if (win_valid && win_ready)  wins++;
      if (done)                    dones++;
      if (win_valid && lb_save_data) overlaps++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkCycle(input string tag, input logic rd, input int addr, input logic save,
                            input logic [31:0] din, input int la, input int vc,
                            input logic wv, input logic bz, input logic dn);
    checkOutput({tag, ".rd_en"},   32'(mem_rd_en),         32'(rd));
    checkOutput({tag, ".addr"},    32'(mem_addr),          32'(addr));
    checkOutput({tag, ".save"},    32'(lb_save_data),      32'(save));
    checkOutput({tag, ".datain"},  lb_datain,              din);
    checkOutput({tag, ".lbaddr"},  32'(lb_address),        32'(la));
    checkOutput({tag, ".vcount"},  32'(lb_vertical_count), 32'(vc));
    checkOutput({tag, ".valid"},   32'(win_valid),         32'(wv));
    checkOutput({tag, ".busy"},    32'(busy),              32'(bz));
    checkOutput({tag, ".done"},    32'(done),              32'(dn));
  endtask

  task automatic expectLoad(input int r);
    for (int k = 0; k <= WPL; k++) begin
      checkCycle($sformatf("load%0d.%0d", r, k), k < WPL, (k < WPL) ? r * WPL + k : 0,
                 k > 0, (k > 0) ? memWord(r * WPL + k - 1) : 32'h0,
                 (k > 0) ? (k - 1) * 4 : 0, r, 1'b0, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic expectScan(input int c);
    for (int k = 0; k < W; k++) begin
      checkCycle($sformatf("scan%0d.%0d", c, k), 1'b0, 0, 1'b0, 32'h0, k, c, 1'b1, 1'b1, 1'b0);
      tick();
    end
  endtask

  task automatic applyStimulus(input logic s, input logic r);
    start = s;
    reset = r;
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    while (!done && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, ".timeout"}, 32'(n >= budget), 32'h0);
    tick();
  endtask

  task automatic clearCounts();
    saves = 0; wins = 0; dones = 0; overlaps = 0;
  endtask

  initial begin
    win_ready = 1'b1;
    applyStimulus(1'b0, 1'b1);
    clearCounts();
    repeat (3) tick();
    checkCycle("reset", 1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);

    // start together with reset must leave the sequencer idle
    applyStimulus(1'b1, 1'b1);
    tick();
    applyStimulus(1'b0, 1'b0);
    tick();
    checkCycle("start_reset", 1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);

    // Frame 1: fully checked cycle by cycle, with a spurious start while busy
    clearCounts();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    expectLoad(0);
    expectLoad(1);
    expectScan(0);
    applyStimulus(1'b1, 1'b0);
    expectLoad(2);
    applyStimulus(1'b0, 1'b0);
    expectScan(1);
    checkCycle("flush", 1'b0, 0, 1'b1, 32'h0, 0, H - 1, 1'b0, 1'b1, 1'b0);
    tick();
    expectScan(2);
    checkCycle("fin", 1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b1);
    tick();
    checkCycle("idle", 1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    checkOutput("f1.saves",   32'(saves),    32'(H * WPL + 1));
    checkOutput("f1.windows", 32'(wins),     32'(H * W));
    checkOutput("f1.dones",   32'(dones),    32'h1);
    checkOutput("f1.overlap", 32'(overlaps), 32'h0);

    // Frame 2: backpressure on the first scanned row
    clearCounts();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    for (int n = 0; n < 20 && !win_valid; n++) tick();
    checkOutput("bp.valid0", 32'(win_valid), 32'h1);
    checkOutput("bp.addr0",  32'(lb_address), 32'h0);
    win_ready = 1'b1; tick();
    checkOutput("bp.addr1",  32'(lb_address), 32'h1);
    win_ready = 1'b0; tick();
    checkOutput("bp.hold1",  32'(lb_address), 32'h1);
    checkOutput("bp.save1",  32'(lb_save_data), 32'h0);
    win_ready = 1'b0; tick();
    checkOutput("bp.hold2",  32'(lb_address), 32'h1);
    checkOutput("bp.save2",  32'(lb_save_data), 32'h0);
    checkOutput("bp.valid2", 32'(win_valid), 32'h1);
    win_ready = 1'b1; tick();
    checkOutput("bp.addr2",  32'(lb_address), 32'h2);
    waitDone("bp", 200);
    checkOutput("f2.saves",   32'(saves), 32'(H * WPL + 1));
    checkOutput("f2.windows", 32'(wins),  32'(H * W));
    checkOutput("f2.dones",   32'(dones), 32'h1);

    // Frame 3: reset during row 1 load with a read in flight, then restart
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    repeat (4) tick();
    checkOutput("rst.inflight", 32'(mem_rd_en), 32'h1);
    checkOutput("rst.addr3",    32'(mem_addr),  32'(WPL + 1));
    applyStimulus(1'b0, 1'b1);
    tick();
    checkCycle("rst.after", 1'b0, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0);
    tick();
    checkOutput("rst.nosave", 32'(lb_save_data), 32'h0);
    clearCounts();
    applyStimulus(1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0);
    checkCycle("restart", 1'b1, 0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b1, 1'b0);
    waitDone("restart", 200);
    checkOutput("f3.saves",   32'(saves), 32'(H * WPL + 1));
    checkOutput("f3.windows", 32'(wins),  32'(H * W));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
